// File: rtl/octree_bus_initiator.sv
// Octree bus initiator: stream SRAM writes, kick CSRs, poll op_done, read back.
// Optional OCTREE_BUS_INIT_STATS_EN adds job_cycles_o and poll_count_o.
module octree_bus_initiator #(
  parameter logic [63:0] CSR0_ADDR  = 64'h6000_0000,
  parameter logic [63:0] CSR1_ADDR  = 64'h6001_0000,
  parameter logic [63:0] CTRL_ADDR  = 64'h600F_0000,
  parameter int          RD_LATENCY = 2,
  parameter int          POLL_GAP   = 4,
  parameter int          LEN_W      = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [63:0]      csr0_i,
  input  logic [63:0]      csr1_i,
  input  logic [1:0]       expect_done_i,
  input  logic [15:0]      poll_max_i,
  input  logic [63:0]      wr_base_i,
  input  logic [LEN_W-1:0] wr_len_i,
  input  logic             wr_valid_i,
  input  logic [63:0]      wr_data_i,
  output logic             wr_ready_o,
  input  logic [63:0]      rd_base_i,
  input  logic [LEN_W-1:0] rd_len_i,
  output logic             rd_valid_o,
  output logic [63:0]      rd_data_o,
  input  logic             rd_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
`ifdef OCTREE_BUS_INIT_STATS_EN
  output logic [31:0]      job_cycles_o,
  output logic [15:0]      poll_count_o,
`endif
  output logic             mem_req_o,
  output logic             mem_write_en_o,
  output logic [7:0]       mem_byte_en_o,
  output logic [63:0]      mem_addr_o,
  output logic [63:0]      mem_wdata_o,
  input  logic [63:0]      mem_rdata_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DATA, S_WR_CSR1, S_WR_CSR0,
    S_POLL_REQ, S_POLL_WAIT, S_POLL_GAP,
    S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_CLEAR, S_DONE
  } state_t;

  localparam logic [7:0]  LAT      = 8'(RD_LATENCY);
  localparam logic [7:0]  GAP_LAST = 8'(POLL_GAP - 1);
  localparam logic [63:0] CLR_MASK = ~(64'h3 << 48);
  localparam logic [63:0] AL_MASK  = ~64'h7;

  state_t           state;
  logic [63:0]      csr0_q, csr1_q, wbase_q, rbase_q;
  logic [1:0]       exp_q;
  logic [15:0]      pmax_q, pcnt, pcnt_nx;
  logic [LEN_W-1:0] wlen_q, rlen_q, wcnt, rcnt;
  logic [LEN_W-1:0] wcnt_nx, rcnt_nx;
  logic [7:0]       lat, gcnt;

  logic             iss, iss_we;
  logic [63:0]      iss_addr, iss_wdata;
  logic [63:0]      wr_addr, rd_addr, rd_addr_nx;

  assign wcnt_nx    = wcnt + 1'b1;
  assign rcnt_nx    = rcnt + 1'b1;
  assign pcnt_nx    = (pcnt == '1) ? pcnt : pcnt + 16'd1;
  assign wr_addr    = (wbase_q & AL_MASK) + (64'(wcnt) << 3);
  assign rd_addr    = (rbase_q & AL_MASK) + (64'(rcnt) << 3);
  assign rd_addr_nx = (rbase_q & AL_MASK) + (64'(rcnt_nx) << 3);

  // Bus access issued at the coming edge, registered onto mem_*_o.
  always_comb begin
    iss       = 1'b0;
    iss_we    = 1'b0;
    iss_addr  = '0;
    iss_wdata = '0;
    case (state)
      S_WR_DATA: if (wr_valid_i && wr_ready_o) begin
        iss = 1'b1; iss_we = 1'b1;
        iss_addr = wr_addr; iss_wdata = wr_data_i;
      end
      S_WR_CSR1: begin
        iss = 1'b1; iss_we = 1'b1;
        iss_addr = CSR1_ADDR; iss_wdata = csr1_q;
      end
      S_WR_CSR0: begin
        iss = 1'b1; iss_we = 1'b1;
        iss_addr = CSR0_ADDR; iss_wdata = csr0_q;
      end
      S_POLL_REQ: begin
        iss = 1'b1; iss_addr = CTRL_ADDR;
      end
      S_POLL_GAP: if (gcnt == GAP_LAST) begin
        iss = 1'b1; iss_addr = CTRL_ADDR;
      end
      S_RD_REQ: begin
        iss = 1'b1; iss_addr = rd_addr;
      end
      S_RD_OUT: if (rd_ready_i && rcnt_nx != rlen_q) begin
        iss = 1'b1; iss_addr = rd_addr_nx;
      end
      S_CLEAR: begin
        iss = 1'b1; iss_we = 1'b1;
        iss_addr = CSR0_ADDR; iss_wdata = csr0_q & CLR_MASK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      csr0_q <= '0; csr1_q <= '0;
      wbase_q <= '0; rbase_q <= '0;
      exp_q <= '0; pmax_q <= '0; pcnt <= '0;
      wlen_q <= '0; rlen_q <= '0;
      wcnt <= '0; rcnt <= '0;
      lat <= '0; gcnt <= '0;
      wr_ready_o <= 1'b0; rd_valid_o <= 1'b0;
      rd_data_o <= '0;
      busy_o <= 1'b0; done_o <= 1'b0; err_o <= 1'b0;
      mem_req_o <= 1'b0; mem_write_en_o <= 1'b0;
      mem_byte_en_o <= '0;
      mem_addr_o <= '0; mem_wdata_o <= '0;
    end else begin
      mem_req_o      <= iss;
      mem_write_en_o <= iss_we;
      mem_byte_en_o  <= iss ? 8'hFF : 8'h00;
      mem_addr_o     <= iss_addr;
      mem_wdata_o    <= iss_wdata;
      done_o         <= 1'b0;
      case (state)
        S_IDLE: if (start_i) begin
          csr0_q <= csr0_i; csr1_q <= csr1_i;
          wbase_q <= wr_base_i; rbase_q <= rd_base_i;
          wlen_q <= wr_len_i; rlen_q <= rd_len_i;
          exp_q <= expect_done_i; pmax_q <= poll_max_i;
          wcnt <= '0; rcnt <= '0; pcnt <= '0;
          busy_o <= 1'b1; err_o <= 1'b0;
          if (wr_len_i != '0) begin
            wr_ready_o <= 1'b1;
            state <= S_WR_DATA;
          end else begin
            state <= S_WR_CSR1;
          end
        end
        S_WR_DATA: if (wr_valid_i) begin
          wcnt <= wcnt_nx;
          if (wcnt_nx == wlen_q) begin
            wr_ready_o <= 1'b0;
            state <= S_WR_CSR1;
          end
        end
        S_WR_CSR1: state <= S_WR_CSR0;
        S_WR_CSR0: state <= S_POLL_REQ;
        S_POLL_REQ: begin
          lat <= '0;
          state <= S_POLL_WAIT;
        end
        S_POLL_WAIT: if (lat == LAT) begin
          if (mem_rdata_i[1:0] == exp_q) begin
            state <= (rlen_q == '0) ? S_CLEAR : S_RD_REQ;
          end else begin
            pcnt <= pcnt_nx;
            if (pmax_q != '0 && pcnt_nx == pmax_q) begin
              err_o <= 1'b1;
              state <= S_CLEAR;
            end else begin
              gcnt <= '0;
              state <= S_POLL_GAP;
            end
          end
        end else begin
          lat <= lat + 8'd1;
        end
        // Last gap cycle issues the next poll directly.
        S_POLL_GAP: if (gcnt == GAP_LAST) begin
          lat <= '0;
          state <= S_POLL_WAIT;
        end else begin
          gcnt <= gcnt + 8'd1;
        end
        S_RD_REQ: begin
          lat <= '0;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: if (lat == LAT) begin
          rd_data_o <= mem_rdata_i;
          rd_valid_o <= 1'b1;
          state <= S_RD_OUT;
        end else begin
          lat <= lat + 8'd1;
        end
        S_RD_OUT: if (rd_ready_i) begin
          rd_valid_o <= 1'b0;
          rcnt <= rcnt_nx;
          if (rcnt_nx == rlen_q) begin
            state <= S_CLEAR;
          end else begin
            lat <= '0;
            state <= S_RD_WAIT;
          end
        end
        S_CLEAR: state <= S_DONE;
        S_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef OCTREE_BUS_INIT_STATS_EN
  logic poll_iss;
  assign poll_iss = (state == S_POLL_REQ) ||
                    (state == S_POLL_GAP && gcnt == GAP_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      job_cycles_o <= '0;
      poll_count_o <= '0;
    end else if (state == S_IDLE) begin
      if (start_i) begin
        job_cycles_o <= 32'd1;
        poll_count_o <= '0;
      end
    end else begin
      if (job_cycles_o != '1)
        job_cycles_o <= job_cycles_o + 32'd1;
      if (poll_iss && poll_count_o != '1)
        poll_count_o <= poll_count_o + 16'd1;
    end
  end
`endif

endmodule
